// File: rtl/set_acc_ctrl.sv
// Controller for a set-match accumulator: sequences clear, beat acceptance, drain
// and result hand-off, and keeps a wide shadow hit count for overflow detection.
module set_acc_ctrl #(
  parameter int LEN_W = 8,
  parameter int SUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             hit_valid,
  input  logic [3:0]       hit,
  output logic             hit_ready,
  output logic             acc_clr,
  output logic             acc_en,
  input  logic [SUM_W-1:0] candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] result,
  output logic             ovf
);

  localparam int SH_W = SUM_W + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [SH_W-1:0]  shadow;
  logic             clr_pend;
  logic             abort_act;
  logic             accept;
  logic             last_beat;
  logic [2:0]       hit_pop;

  always_comb begin
    hit_pop = {2'b00, hit[0]} + {2'b00, hit[1]} + {2'b00, hit[2]} + {2'b00, hit[3]};
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != S_IDLE);
    hit_ready = 1'b0;
    acc_en    = 1'b0;
    accept    = 1'b0;
    res_valid = 1'b0;
    acc_clr   = clr_pend;
    abort_act = abort && (state != S_IDLE);
    last_beat = ((beat_cnt + LEN_W'(1)) == len_q);

    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clr  = 1'b1;
        state_nx = (len_q != '0) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        hit_ready = 1'b1;
        acc_en    = hit_valid;
        accept    = hit_valid;
        if (hit_valid && last_beat) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        state_nx = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // abort wins over everything and suppresses the beat of its own cycle
    if (abort_act) begin
      state_nx  = S_IDLE;
      hit_ready = 1'b0;
      acc_en    = 1'b0;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_pend <= 1'b1;
      len_q    <= '0;
      beat_cnt <= '0;
      shadow   <= '0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      // one extra clear cycle after reset release or an abort
      clr_pend <= abort_act;
      if (state == S_IDLE && start) begin
        len_q    <= len;
        beat_cnt <= '0;
        shadow   <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
        shadow   <= shadow + SH_W'(hit_pop);
      end
      if (state == S_DRAIN && !abort_act) begin
        result <= candidate;
        ovf    <= |shadow[SH_W-1:SUM_W];
      end
    end
  end

endmodule

// File: tb/tb_set_acc_ctrl.sv
// Self-checking bench for set_acc_ctrl with a behavioural accumulator datapath
// driving candidate from acc_clr/acc_en/hit.
module tb_set_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic       abort = 1'b0;
  logic       busy;
  logic       hit_valid = 1'b0;
  logic [3:0] hit = '0;
  logic       hit_ready;
  logic       acc_clr;
  logic       acc_en;
  logic [7:0] candidate = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] result;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  set_acc_ctrl #(.LEN_W(8), .SUM_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .hit_valid (hit_valid),
    .hit       (hit),
    .hit_ready (hit_ready),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .candidate (candidate),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] popcnt(input logic [3:0] h);
    return 8'(h[0]) + 8'(h[1]) + 8'(h[2]) + 8'(h[3]);
  endfunction

  // accumulator datapath model
  always_ff @(posedge clk) begin
    if (acc_clr)     candidate <= '0;
    else if (acc_en) candidate <= candidate + popcnt(hit);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // beat i uses hits[4*(i%4) +: 4]; pre = idle RUN cycles before beat 0,
  // stall = idle RUN cycles between beat 0 and beat 1
  typedef struct {
    logic [7:0]  len;
    logic [15:0] hits;
    int          pre;
    int          stall;
    logic [7:0]  exp_res;
    logic        exp_ovf;
    int          exp_lat;
    bit          hold;
  } vec_t;

  vec_t vecs[6];

  // called at a negedge with the FSM idle; returns at a negedge with the FSM idle
  task automatic run_job(input vec_t v, input int idx);
    int cyc, beat, stall_left, en_cnt, lat;
    bit saw_ready, saw_clr0, acc, got, rdy;
    cyc = 0; beat = 0; en_cnt = 0; lat = -1;
    saw_ready = 0; saw_clr0 = 0; got = 0;
    stall_left = v.pre;
    start = 1'b1;
    len   = v.len;
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'hAA;
    while (!got && cyc < 300) begin
      hit_valid = (beat < int'(v.len)) && (stall_left == 0);
      hit       = v.hits[4*(beat%4) +: 4];
      @(negedge clk);
      if (cyc == 0) saw_clr0 = acc_clr;
      rdy = hit_ready;
      if (hit_ready) saw_ready = 1;
      if (acc_en) en_cnt++;
      acc = hit_valid && hit_ready;
      if (res_valid) begin
        got = 1;
        lat = cyc;
      end else begin
        @(posedge clk); #1;
        if (acc) begin
          beat++;
          if (beat == 1) stall_left = v.stall;
        end else if (rdy && stall_left > 0) begin
          stall_left--;
        end
        cyc++;
      end
    end
    hit_valid = 1'b0;
    chk($sformatf("v%0d res_valid_seen", idx), 32'(got), 1);
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d result", idx), 32'(result), 32'(v.exp_res));
    chk($sformatf("v%0d ovf", idx), 32'(ovf), 32'(v.exp_ovf));
    chk($sformatf("v%0d acc_en_pulses", idx), 32'(en_cnt), 32'(v.len));
    chk($sformatf("v%0d hit_ready_seen", idx), 32'(saw_ready), 32'(v.len != 0));
    chk($sformatf("v%0d acc_clr_in_clear", idx), 32'(saw_clr0), 1);
    if (v.hold) begin
      res_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("v%0d hold%0d res_valid", idx, i), 32'(res_valid), 1);
        chk($sformatf("v%0d hold%0d result", idx, i), 32'(result), 32'(v.exp_res));
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      start     = 1'b1;
      len       = 8'd3;
      @(posedge clk); #1;
      res_ready = 1'b0;
      start     = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d done_start_ignored", idx), 32'(busy), 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d still_idle", idx), 32'(busy), 0);
    end else begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d idle_after_done", idx), 32'(busy), 0);
      chk($sformatf("v%0d res_valid_dropped", idx), 32'(res_valid), 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " acc_clr"}, 32'(acc_clr), 1);
    chk({tag, " acc_en"}, 32'(acc_en), 0);
    chk({tag, " hit_ready"}, 32'(hit_ready), 0);
    chk({tag, " res_valid"}, 32'(res_valid), 0);
    chk({tag, " result"}, 32'(result), 0);
    chk({tag, " ovf"}, 32'(ovf), 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{len: 8'd3,  hits: 16'h015F, pre: 0, stall: 0, exp_res: 8'd7, exp_ovf: 1'b0, exp_lat: 5,  hold: 1'b1};
    vecs[1] = '{len: 8'd2,  hits: 16'h0083, pre: 1, stall: 3, exp_res: 8'd3, exp_ovf: 1'b0, exp_lat: 8,  hold: 1'b0};
    vecs[2] = '{len: 8'd0,  hits: 16'h0000, pre: 0, stall: 0, exp_res: 8'd0, exp_ovf: 1'b0, exp_lat: 2,  hold: 1'b0};
    vecs[3] = '{len: 8'd65, hits: 16'hFFFF, pre: 0, stall: 0, exp_res: 8'd4, exp_ovf: 1'b1, exp_lat: 67, hold: 1'b0};
    vecs[4] = '{len: 8'd4,  hits: 16'hE7A0, pre: 0, stall: 0, exp_res: 8'd8, exp_ovf: 1'b0, exp_lat: 6,  hold: 1'b0};
    vecs[5] = '{len: 8'd1,  hits: 16'h0006, pre: 0, stall: 0, exp_res: 8'd2, exp_ovf: 1'b0, exp_lat: 3,  hold: 1'b0};

    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset acc_clr_held", 32'(acc_clr), 1);
    chk("post_reset busy", 32'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    chk("post_reset acc_clr_low", 32'(acc_clr), 0);

    for (int i = 0; i < 5; i++) run_job(vecs[i], i);

    // abort after 2 of 5 beats
    start = 1'b1; len = 8'd5; hit_valid = 1'b1; hit = 4'hF;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int g = 0; g < 20 && n < 2; g++) begin
      @(negedge clk);
      if (acc_en) n++;
      @(posedge clk); #1;
    end
    chk("abort beats_before", 32'(n), 2);
    abort = 1'b1;
    @(negedge clk);
    chk("abort acc_en_masked", 32'(acc_en), 0);
    chk("abort hit_ready_masked", 32'(hit_ready), 0);
    chk("abort busy_before_edge", 32'(busy), 1);
    @(posedge clk); #1;
    abort = 1'b0; hit_valid = 1'b0;
    @(negedge clk);
    chk("abort idle", 32'(busy), 0);
    chk("abort acc_clr_pulse", 32'(acc_clr), 1);
    chk("abort res_valid", 32'(res_valid), 0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort acc_clr_one_cycle", 32'(acc_clr), 0);
    chk("abort model_cleared", 32'(candidate), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort no_clr", 32'(acc_clr), 0);
    chk("idle_abort busy", 32'(busy), 0);
    chk("idle_abort res_valid", 32'(res_valid), 0);
    run_job(vecs[5], 5);

    // asynchronous reset in the middle of RUN
    start = 1'b1; len = 8'd5; hit_valid = 1'b1; hit = 4'h3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("midrun busy_before_rst", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk_reset_vals("midrun_rst");
    @(posedge clk); #1;
    rst = 1'b1; hit_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid || busy) n++;
      @(posedge clk); #1;
    end
    chk("midrun no_result_after_rst", 32'(n), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
